// File: rtl/game_ctrl.sv
// rtl/game_ctrl.sv - frame-rate title/play/over sequencer with platform scroll and scoring
// Optional pause state is built only when GAME_CTRL_PAUSE_EN is defined.
module game_ctrl #(
  parameter int         SCROLL_LINE = 200,
  parameter int         OVER_HOLD   = 60,
  parameter logic [9:0] LFSR_SEED   = 10'h2A5
) (
  input  logic        frame_clk,
  input  logic        Reset,
  input  logic [7:0]  keycode,
  input  logic        gg,
  input  logic [10:0] BallY,
  output logic [1:0]  game_state,
  output logic        ball_reset,
  output logic        freeze,
  output logic [15:0] score,
  output logic [15:0] high_score,
  output logic [9:0]  plat_x0,
  output logic [9:0]  plat_x1,
  output logic [9:0]  plat_x2,
  output logic [9:0]  plat_y0,
  output logic [9:0]  plat_y1,
  output logic [9:0]  plat_y2
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_PLAY = 2'd1, S_OVER = 2'd2, S_PAUSE = 2'd3} state_t;

  localparam int HW = (OVER_HOLD > 1) ? $clog2(OVER_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_MAX = HW'(OVER_HOLD - 1);
  localparam logic [9:0] PX_INIT [3] = '{10'd240, 10'd165, 10'd317};
  localparam logic [9:0] PY_INIT [3] = '{10'd470, 10'd315, 10'd160};

  state_t        state, state_next;
  logic          ball_reset_d, freeze_d;
  logic [7:0]    key_prev;
  logic [9:0]    lfsr;
  logic [HW-1:0] hold_cnt;
  logic [9:0]    px [3];
  logic [9:0]    py [3];
  logic [9:0]    rot [3];
  logic [9:0]    respawn_x [3];
  logic          ev_space, ev_r, do_load, do_scroll;

  assign ev_space  = (keycode == 8'h2C) && (key_prev != 8'h2C);
  assign ev_r      = (keycode == 8'h15) && (key_prev != 8'h15);
  assign do_load   = (state == S_IDLE) && ev_space;
  assign do_scroll = (state == S_PLAY) && !gg && (BallY < 11'(SCROLL_LINE));

`ifdef GAME_CTRL_PAUSE_EN
  logic ev_p;
  assign ev_p = (keycode == 8'h13) && (key_prev != 8'h13);
`endif

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (ev_space) state_next = S_PLAY;
      S_PLAY: begin
        if (gg) state_next = S_OVER;
`ifdef GAME_CTRL_PAUSE_EN
        else if (ev_p) state_next = S_PAUSE;
`endif
      end
      S_OVER: if (ev_r && (hold_cnt == HOLD_MAX)) state_next = S_IDLE;
`ifdef GAME_CTRL_PAUSE_EN
      S_PAUSE: if (ev_p) state_next = S_PLAY;
`endif
      default: state_next = S_IDLE;
    endcase
  end

  // Ball-block controls are decoded from the next state so they change on the same edge as the state.
  always_comb begin
    ball_reset_d = 1'b0;
    freeze_d     = 1'b1;
    case (state_next)
      S_IDLE:  ball_reset_d = 1'b1;
      S_PLAY:  freeze_d     = 1'b0;
      default: ;
    endcase
  end

  // Each platform sees a different rotation so simultaneous respawns land apart.
  always_comb begin
    rot[0] = lfsr;
    rot[1] = {lfsr[6:0], lfsr[9:7]};
    rot[2] = {lfsr[3:0], lfsr[9:4]};
    for (int i = 0; i < 3; i++) respawn_x[i] = 10'd40 + {1'b0, rot[i][8:0]};
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      ball_reset <= 1'b1;
      freeze     <= 1'b1;
      key_prev   <= 8'h00;
      lfsr       <= LFSR_SEED;
      hold_cnt   <= '0;
      score      <= 16'h0000;
      high_score <= 16'h0000;
      for (int i = 0; i < 3; i++) begin
        px[i] <= PX_INIT[i];
        py[i] <= PY_INIT[i];
      end
    end else begin
      ball_reset <= ball_reset_d;
      freeze     <= freeze_d;
      key_prev   <= keycode;
      lfsr       <= {lfsr[8:0], lfsr[9] ^ lfsr[6]};
      if (do_load) begin
        score <= 16'h0000;
        for (int i = 0; i < 3; i++) begin
          px[i] <= PX_INIT[i];
          py[i] <= PY_INIT[i];
        end
      end else if (do_scroll) begin
        if (score != 16'hFFFF) score <= score + 16'd1;
        for (int i = 0; i < 3; i++) begin
          if (({1'b0, py[i]} + 11'd1) >= 11'd480) begin
            py[i] <= 10'd0;
            px[i] <= respawn_x[i];
          end else begin
            py[i] <= py[i] + 10'd1;
          end
        end
      end
      if ((state == S_PLAY) && gg) begin
        hold_cnt <= '0;
        if (score > high_score) high_score <= score;
      end else if ((state == S_OVER) && (hold_cnt != HOLD_MAX)) begin
        hold_cnt <= hold_cnt + HW'(1);
      end
    end
  end

  assign game_state = state;
  assign plat_x0    = px[0];
  assign plat_x1    = px[1];
  assign plat_x2    = px[2];
  assign plat_y0    = py[0];
  assign plat_y1    = py[1];
  assign plat_y2    = py[2];

endmodule

// File: tb/tb_game_ctrl.sv
// tb/tb_game_ctrl.sv - directed and randomized checks of game_ctrl against a frame-level game model
module tb_game_ctrl;

`ifdef GAME_CTRL_PAUSE_EN
  localparam bit PAUSE_EN = 1'b1;
`else
  localparam bit PAUSE_EN = 1'b0;
`endif
  localparam int HOLD = 60;

  logic        frame_clk = 1'b0;
  logic        Reset;
  logic [7:0]  keycode;
  logic        gg;
  logic [10:0] BallY;
  logic [1:0]  game_state;
  logic        ball_reset, freeze;
  logic [15:0] score, high_score;
  logic [9:0]  plat_x0, plat_x1, plat_x2, plat_y0, plat_y1, plat_y2;

  int n_checks = 0;
  int n_pass   = 0;

  int m_st, m_score, m_high, m_lfsr, m_kprev, m_ovf;
  int m_px [3];
  int m_py [3];

  game_ctrl dut (
    .frame_clk(frame_clk), .Reset(Reset), .keycode(keycode), .gg(gg), .BallY(BallY),
    .game_state(game_state), .ball_reset(ball_reset), .freeze(freeze),
    .score(score), .high_score(high_score),
    .plat_x0(plat_x0), .plat_x1(plat_x1), .plat_x2(plat_x2),
    .plat_y0(plat_y0), .plat_y1(plat_y1), .plat_y2(plat_y2)
  );

  always #5 frame_clk = ~frame_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic load_plats();
    m_px = '{240, 165, 317};
    m_py = '{470, 315, 160};
  endtask

  task automatic model_reset();
    m_st = 0; m_score = 0; m_high = 0; m_lfsr = 'h2A5; m_kprev = 0; m_ovf = 0;
    load_plats();
  endtask

  task automatic model_step(input int k, input bit g, input int by);
    bit sp, re, pe;
    int rot;
    sp = (k == 'h2C) && (m_kprev != 'h2C);
    re = (k == 'h15) && (m_kprev != 'h15);
    pe = (k == 'h13) && (m_kprev != 'h13);
    case (m_st)
      0: if (sp) begin m_st = 1; m_score = 0; load_plats(); end
      1: begin
        if (g) begin
          m_st = 2; m_ovf = 0;
          if (m_score > m_high) m_high = m_score;
        end else begin
          if (PAUSE_EN && pe) m_st = 3;
          if (by < 200) begin
            if (m_score < 65535) m_score++;
            for (int i = 0; i < 3; i++) begin
              if (m_py[i] + 1 >= 480) begin
                rot = ((m_lfsr << (3 * i)) | (m_lfsr >> (10 - 3 * i))) & 'h3FF;
                m_py[i] = 0;
                m_px[i] = 40 + (rot % 512);
              end else m_py[i] = m_py[i] + 1;
            end
          end
        end
      end
      2: begin
        if (re && m_ovf >= HOLD - 1) m_st = 0;
        else if (m_ovf < HOLD - 1) m_ovf++;
      end
      default: if (pe) m_st = 1;
    endcase
    m_kprev = k;
    m_lfsr = ((m_lfsr << 1) | (((m_lfsr >> 9) ^ (m_lfsr >> 6)) & 1)) & 'h3FF;
  endtask

  task automatic check_model();
    chk("game_state", game_state, m_st);
    chk("ball_reset", ball_reset, (m_st == 0));
    chk("freeze", freeze, (m_st != 1));
    chk("score", score, m_score);
    chk("high_score", high_score, m_high);
    chk("plat_x0", plat_x0, m_px[0]);
    chk("plat_x1", plat_x1, m_px[1]);
    chk("plat_x2", plat_x2, m_px[2]);
    chk("plat_y0", plat_y0, m_py[0]);
    chk("plat_y1", plat_y1, m_py[1]);
    chk("plat_y2", plat_y2, m_py[2]);
  endtask

  task automatic frame(input logic [7:0] k, input logic g, input logic [10:0] by);
    keycode = k; gg = g; BallY = by;
    model_step(int'(k), g, int'(by));
    @(posedge frame_clk);
    #1;
    check_model();
  endtask

  initial begin
    logic [7:0] k;
    int r;
    Reset = 1'b1; keycode = 8'h00; gg = 1'b0; BallY = 11'd300;
    model_reset();
    #12;
    check_model();
    chk("reset_state", game_state, 0);
    chk("reset_ball_reset", ball_reset, 1);
    @(negedge frame_clk);
    Reset = 1'b0;

    // Title to play on a single Space frame
    frame(8'h2C, 1'b0, 11'd300);
    chk("space_state", game_state, 1);
    chk("space_ball_reset", ball_reset, 0);
    chk("space_y0", plat_y0, 470);
    chk("space_x2", plat_x2, 317);

    // Climbing: platform 0 reaches 479 then respawns on the tenth scroll
    repeat (9) frame(8'h00, 1'b0, 11'd150);
    chk("y0_before_wrap", plat_y0, 479);
    frame(8'h00, 1'b0, 11'd150);
    chk("y0_wrapped", plat_y0, 0);
    chk("score_10", score, 10);
    chk("x0_range", (plat_x0 >= 10'd40) && (plat_x0 <= 10'd551), 1);

    // gg beats scroll in the same frame
    frame(8'h00, 1'b1, 11'd150);
    chk("gg_state", game_state, 2);
    chk("gg_score", score, 10);
    chk("gg_high", high_score, 10);

    // Restart only once the hold has elapsed
    for (int f = 1; f <= 61; f++) begin
      frame((f == 30 || f == 59 || f == 61) ? 8'h15 : 8'h00, 1'b0, 11'd150);
      if (f == 30) chk("r_early_30", game_state, 2);
      if (f == 59) chk("r_early_59", game_state, 2);
    end
    chk("r_accept_state", game_state, 0);
    chk("r_accept_ball_reset", ball_reset, 1);

    // Held Space fires once; held Space in play is ignored
    for (int f = 0; f < 5; f++) begin
      frame(8'h2C, 1'b0, 11'd300);
      chk("space_held", game_state, 1);
    end
    chk("high_kept", high_score, 10);

`ifdef GAME_CTRL_PAUSE_EN
    frame(8'h13, 1'b0, 11'd300);
    chk("pause_enter", game_state, 3);
    frame(8'h00, 1'b1, 11'd150);
    chk("pause_gg_ignored", game_state, 3);
    frame(8'h13, 1'b0, 11'd300);
    chk("pause_exit", game_state, 1);
`else
    frame(8'h13, 1'b0, 11'd300);
    chk("p_ignored", game_state, 1);
`endif

    // Randomized play against the model
    for (int n = 0; n < 500; n++) begin
      r = int'($urandom_range(0, 9));
      case (r)
        0: k = 8'h2C;
        1: k = 8'h15;
        2: k = 8'h13;
        3: k = 8'($urandom);
        default: k = 8'h00;
      endcase
      frame(k, ($urandom_range(0, 15) == 0), 11'($urandom_range(0, 400)));
    end

    // Mid-game reset clears everything, including the high score
    frame(8'h00, 1'b0, 11'd150);
    Reset = 1'b1;
    model_reset();
    #1;
    check_model();
    chk("reset_high", high_score, 0);
    @(negedge frame_clk);
    Reset = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
